ingress_framer: RTL and testbench
=================================

Name: ingress_framer

Overview:
- Upstream neighbour of the ingress VOQ/buffer stage.
- Accepts a word stream from the port MAC/DMA side (valid/ready with last), parses the header word, and admits or drops each packet against the ingress free-block count.
- Admitted packets are re-emitted to ingress as a 32-byte-block-aligned word stream: `new_packet_en` on the header word, `write_en` on every word, and zero padding to the next 8-word block boundary.

Parameters:
- DATA_WIDTH, 32, stream and output word width.
- BLOCK_WORDS, 8, words per 32-byte ingress block (power of two).
- MAX_LEN, 2016, largest legal packet length in bytes (63 blocks, fits ingress 6-bit block count).
- FREE_W, 10, width of the free-block count from ingress.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- s_data  in  DATA_WIDTH  stream word; the first word of a packet is the header: [15:0] len_bytes including the 4-byte header, [17:16] dest_port
- s_valid  in  1  s_data valid
- s_last  in  1  final word of the packet
- s_ready  out  1  framer accepts s_data this cycle
- free_blocks  in  FREE_W  empty blocks currently available in ingress
- packet_out  out  DATA_WIDTH  word to ingress `packet_in`
- write_en  out  1  packet_out valid
- new_packet_en  out  1  packet_out is a header word (first word of packet)
- dest_port  out  2  destination of the current packet, held from header until the next header
- drop_cnt  out  CNT_W  packets dropped for lack of space or bad length, saturating
- err_cnt  out  CNT_W  packets whose s_last disagreed with len_bytes, saturating

Behaviour:
- Reset:
  - All outputs are 0, except s_ready, which is 0 during reset and 1 in IDLE after reset.
  - FSM goes to IDLE; counters are cleared.
  - Reset mid-packet abandons the packet; no further write_en is issued.
- Derived values, computed from the header:
  - blocks = ceil(len/32).
  - words = ceil(len/4).
  - total = blocks*BLOCK_WORDS.
  - All arithmetic is unsigned and at least 16 bits wide.
- Latency and output timing:
  - Latency is 1 cycle: an accepted word (s_valid&&s_ready) appears registered on packet_out with write_en=1 the next cycle.
  - write_en is 0 in every cycle that carries no word.
- States:
  - IDLE, s_ready=1. An accepted word is a header.
    - Bad length (len==0 or len>MAX_LEN): drop_cnt++; go to DROP, or stay in IDLE if s_last.
    - blocks > free_blocks: drop_cnt++; same DROP/IDLE rule.
    - Otherwise emit the header with new_packet_en=1 and latch dest_port, words, total. out_cnt=1.
    - Next state after admission:
      - words==1 and s_last: PAD, or IDLE if total==1 (impossible with BLOCK_WORDS=8).
      - words==1 and not s_last: DRAIN, err_cnt++.
      - Otherwise: BODY.
  - BODY, s_ready=1. Each accepted word is emitted and out_cnt++.
    - Declared length reached with s_last: go to PAD if out_cnt<total, else IDLE.
    - Declared length reached without s_last: truncate, err_cnt++, go to DRAIN.
    - s_last before the declared length: err_cnt++, go to PAD. PAD fills the full total, so ingress receives exactly the words it allocated.
  - PAD, s_ready=0. Emit zero words with write_en=1 until out_cnt==total, then go to IDLE.
  - DRAIN and DROP, s_ready=1. Discard words with no write_en until s_last, then go to IDLE.
- free_blocks is sampled only in the header acceptance cycle; later changes do not affect an admitted packet.
- Counters hold at all-ones (saturate) rather than wrapping.
- out_cnt is 0..total and never exceeds total.
- Back-to-back packets: a header may be accepted in the cycle after BODY ends with s_last when no padding is needed (out_cnt==total).

Decomposition:
- Shared package `switch_pkg`:
  - Header field constants (LEN_LSB=0, LEN_MSB=15, DEST_LSB=16, DEST_MSB=17).
  - BLOCK_BYTES=32, BLOCK_WORDS=8, MAX_LEN.
  - Typedef `port_id_t` (2-bit), typedef `framer_state_e`.
- One natural sub-module, `sat_counter`, instantiated twice for drop_cnt and err_cnt. The FSM and datapath stay in ingress_framer.

Test Plan:
- Header len=64, dest=2, then 15 words with s_last on the last, free_blocks=10 -> 16 write_en cycles, new_packet_en only on the first, dest_port=2, no padding, back to IDLE.
- len=40 (10 words, blocks=2), s_last on word 10 -> 10 data words then 6 zero words, s_ready=0 for those 6 cycles, 16 total write_en.
- len=256 (8 blocks), free_blocks=7 -> zero write_en, all 64 words consumed with s_ready=1, drop_cnt=1.
- len=64 but s_last on word 5 -> 5 data words + 11 zeros, err_cnt=1; a second case with s_last on word 20 -> 16 words emitted, 4 discarded, err_cnt=2.
- len=0 header, and separately len=2048 -> both dropped, drop_cnt=2, no write_en; then force drop_cnt to 0xFFFF and drop once more -> stays 0xFFFF.
- rst_n low during BODY word 4 -> write_en=0 immediately, s_ready=0 while reset is held, IDLE after release; the next valid packet is framed correctly.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared switch definitions: header field layout, block geometry and framer state encoding.
package switch_pkg;

  // Header word field positions
  localparam int LEN_LSB  = 0;
  localparam int LEN_MSB  = 15;
  localparam int DEST_LSB = 16;
  localparam int DEST_MSB = 17;

  // Ingress block geometry and largest packet that fits a 6-bit block count
  localparam int BLOCK_BYTES = 32;
  localparam int BLOCK_WORDS = 8;
  localparam int MAX_LEN     = 2016;

  typedef logic [1:0] port_id_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BODY  = 3'd1,
    ST_PAD   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DROP  = 3'd4
  } framer_state_e;

  // ceil(len / 2**sh), widened by one bit so len=0xFFFF cannot wrap
  function automatic logic [16:0] ceil_shift(input logic [15:0] len, input int unsigned sh);
    logic [16:0] round_s;
    round_s = (17'd1 << sh) - 17'd1;
    return ({1'b0, len} + round_s) >> sh;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: increments on inc and holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic at_max_s;

  assign at_max_s = (count == {W{1'b1}});

  // Count register; a pending increment at the maximum value is absorbed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {W{1'b0}};
    end else if (inc && !at_max_s) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/ingress_framer.sv
// Ingress framer: parses the header word, admits or drops the packet against the
// ingress free-block count, and re-emits admitted packets padded to whole blocks.
module ingress_framer #(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = switch_pkg::BLOCK_WORDS,
  parameter int MAX_LEN     = switch_pkg::MAX_LEN,
  parameter int FREE_W      = 10,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic [FREE_W-1:0]     free_blocks,
  output logic [DATA_WIDTH-1:0] packet_out,
  output logic                  write_en,
  output logic                  new_packet_en,
  output logic [1:0]            dest_port,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic [CNT_W-1:0]      err_cnt
);

  import switch_pkg::*;

  // Byte shift for one block and word shift for one block
  localparam int unsigned BLK_BYTE_SH = $clog2(BLOCK_WORDS * 4);
  localparam int unsigned BLK_WORD_SH = $clog2(BLOCK_WORDS);

  framer_state_e state_r, state_n;

  logic [16:0]           out_cnt_r, out_cnt_n;
  logic [16:0]           words_r, words_n;
  logic [16:0]           total_r, total_n;
  port_id_t              dest_r, dest_n;
  logic [DATA_WIDTH-1:0] pkt_r, pkt_n;
  logic                  we_r, we_n;
  logic                  npe_r, npe_n;
  logic                  ready_r, ready_n;

  logic        accept_s;
  logic [15:0] len_s;
  logic [16:0] blocks_s;
  logic [16:0] words_s;
  logic [16:0] total_s;
  logic        len_bad_s;
  logic        no_room_s;
  logic [16:0] cnt_inc_s;
  logic        drop_inc_s;
  logic        err_inc_s;

  assign accept_s  = s_valid && ready_r;
  assign len_s     = s_data[LEN_MSB:LEN_LSB];
  assign blocks_s  = ceil_shift(len_s, BLK_BYTE_SH);
  assign words_s   = ceil_shift(len_s, 32'd2);
  assign total_s   = blocks_s << BLK_WORD_SH;
  assign len_bad_s = (len_s == 16'd0) || ({1'b0, len_s} > 17'(MAX_LEN));
  assign no_room_s = blocks_s > 17'(free_blocks);
  assign cnt_inc_s = out_cnt_r + 17'd1;

  // Next-state and next-output decode for the framing FSM
  always_comb begin
    state_n    = state_r;
    out_cnt_n  = out_cnt_r;
    words_n    = words_r;
    total_n    = total_r;
    dest_n     = dest_r;
    pkt_n      = {DATA_WIDTH{1'b0}};
    we_n       = 1'b0;
    npe_n      = 1'b0;
    drop_inc_s = 1'b0;
    err_inc_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (len_bad_s || no_room_s) begin
            drop_inc_s = 1'b1;
            state_n    = s_last ? ST_IDLE : ST_DROP;
          end else begin
            pkt_n     = s_data;
            we_n      = 1'b1;
            npe_n     = 1'b1;
            dest_n    = s_data[DEST_MSB:DEST_LSB];
            words_n   = words_s;
            total_n   = total_s;
            out_cnt_n = 17'd1;
            if (words_s == 17'd1) begin
              if (s_last) begin
                state_n = (total_s == 17'd1) ? ST_IDLE : ST_PAD;
              end else begin
                // Header-only length but more words follow: discard the rest
                state_n   = ST_DRAIN;
                err_inc_s = 1'b1;
              end
            end else begin
              state_n = ST_BODY;
            end
          end
        end else begin
          state_n = ST_IDLE;
        end
      end

      ST_BODY: begin
        if (accept_s) begin
          pkt_n     = s_data;
          we_n      = 1'b1;
          out_cnt_n = cnt_inc_s;
          if (cnt_inc_s == words_r) begin
            if (s_last) begin
              state_n = (cnt_inc_s < total_r) ? ST_PAD : ST_IDLE;
            end else begin
              // Declared length reached, sender still going: truncate
              err_inc_s = 1'b1;
              state_n   = ST_DRAIN;
            end
          end else if (s_last) begin
            // Short packet: padding still fills the allocated blocks
            err_inc_s = 1'b1;
            state_n   = ST_PAD;
          end else begin
            state_n = ST_BODY;
          end
        end else begin
          state_n = ST_BODY;
        end
      end

      ST_PAD: begin
        we_n      = 1'b1;
        out_cnt_n = cnt_inc_s;
        if (cnt_inc_s >= total_r) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_PAD;
        end
      end

      ST_DRAIN, ST_DROP: begin
        if (accept_s && s_last) begin
          state_n = ST_IDLE;
        end else begin
          state_n = state_r;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Ready is registered from the next state so it is low only while padding
  always_comb begin
    ready_n = (state_n != ST_PAD);
  end

  // State, datapath and registered outputs; reset abandons any packet in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      out_cnt_r <= 17'd0;
      words_r   <= 17'd0;
      total_r   <= 17'd0;
      dest_r    <= 2'd0;
      pkt_r     <= {DATA_WIDTH{1'b0}};
      we_r      <= 1'b0;
      npe_r     <= 1'b0;
      ready_r   <= 1'b0;
    end else begin
      state_r   <= state_n;
      out_cnt_r <= out_cnt_n;
      words_r   <= words_n;
      total_r   <= total_n;
      dest_r    <= dest_n;
      pkt_r     <= pkt_n;
      we_r      <= we_n;
      npe_r     <= npe_n;
      ready_r   <= ready_n;
    end
  end

  assign s_ready       = ready_r;
  assign packet_out    = pkt_r;
  assign write_en      = we_r;
  assign new_packet_en = npe_r;
  assign dest_port     = dest_r;

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop_inc_s),
    .count (drop_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc_s),
    .count (err_cnt)
  );

endmodule

// File: tb/tb_ingress_framer.sv
// Directed testbench for ingress_framer with hand-computed expected streams.
module tb_ingress_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [9:0]  free_blocks;
  logic [31:0] packet_out;
  logic        write_en;
  logic        new_packet_en;
  logic [1:0]  dest_port;
  logic [15:0] drop_cnt;
  logic [15:0] err_cnt;

  int tests = 0;
  int fails = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          npe_cnt;
  int          rdy_low;

  ingress_framer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .free_blocks   (free_blocks),
    .packet_out    (packet_out),
    .write_en      (write_en),
    .new_packet_en (new_packet_en),
    .dest_port     (dest_port),
    .drop_cnt      (drop_cnt),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  // Output observer, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (write_en) got_q.push_back(packet_out);
      if (new_packet_en) npe_cnt++;
      if (!s_ready) rdy_low++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    npe_cnt = 0;
    rdy_low = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int w;
    w = 0;
    @(negedge clk);
    s_data  = d;
    s_valid = 1'b1;
    s_last  = l;
    while (!s_ready && w < 600) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) check_eq("ready_timeout", 32'(s_ready), 32'd1);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 32'd0;
    repeat (n) @(negedge clk);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check_eq({tag, "_words"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    s_data      = 32'd0;
    s_valid     = 1'b0;
    s_last      = 1'b0;
    free_blocks = 10'd10;
    clear_obs();

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(s_ready), 32'd0);
    check_eq("rst_we", 32'(write_en), 32'd0);
    check_eq("rst_npe", 32'(new_packet_en), 32'd0);
    check_eq("rst_pkt", packet_out, 32'd0);
    check_eq("rst_dest", 32'(dest_port), 32'd0);
    check_eq("rst_drop", 32'(drop_cnt), 32'd0);
    check_eq("rst_err", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    idle(2);
    check_eq("idle_ready", 32'(s_ready), 32'd1);

    // T1: len=64 dest=2, exactly two blocks, no padding
    clear_obs();
    send(32'h0002_0040, 1'b0);
    exp_q.push_back(32'h0002_0040);
    @(posedge clk);
    #1;
    check_eq("t1_lat_we", 32'(write_en), 32'd1);
    check_eq("t1_lat_npe", 32'(new_packet_en), 32'd1);
    check_eq("t1_lat_pkt", packet_out, 32'h0002_0040);
    for (int i = 1; i <= 15; i++) begin
      send(32'hA000_0000 | 32'(i), i == 15);
      exp_q.push_back(32'hA000_0000 | 32'(i));
    end
    idle(4);
    compare_stream("t1");
    check_eq("t1_npe", 32'(npe_cnt), 32'd1);
    check_eq("t1_dest", 32'(dest_port), 32'd2);
    check_eq("t1_rdy_low", 32'(rdy_low), 32'd0);
    check_eq("t1_ready", 32'(s_ready), 32'd1);

    // T2: len=40 dest=1 -> 10 data words then 6 pad words
    clear_obs();
    send(32'h0001_0028, 1'b0);
    exp_q.push_back(32'h0001_0028);
    for (int i = 1; i <= 9; i++) begin
      send(32'hB000_0000 | 32'(i), i == 9);
      exp_q.push_back(32'hB000_0000 | 32'(i));
    end
    for (int i = 0; i < 6; i++) exp_q.push_back(32'd0);
    idle(12);
    compare_stream("t2");
    check_eq("t2_npe", 32'(npe_cnt), 32'd1);
    check_eq("t2_dest", 32'(dest_port), 32'd1);
    check_eq("t2_rdy_low", 32'(rdy_low), 32'd6);

    // T3: len=256 needs 8 blocks, only 7 free -> dropped, all words consumed
    clear_obs();
    free_blocks = 10'd7;
    send(32'h0000_0100, 1'b0);
    for (int i = 1; i <= 63; i++) send(32'hC000_0000 | 32'(i), i == 63);
    idle(4);
    free_blocks = 10'd10;
    check_eq("t3_words", 32'(got_q.size()), 32'd0);
    check_eq("t3_rdy_low", 32'(rdy_low), 32'd0);
    check_eq("t3_drop", 32'(drop_cnt), 32'd1);

    // T4a: len=64 but s_last on word 5 -> 5 data + 11 zeros
    clear_obs();
    send(32'h0000_0040, 1'b0);
    exp_q.push_back(32'h0000_0040);
    for (int i = 1; i <= 4; i++) begin
      send(32'hD000_0000 | 32'(i), i == 4);
      exp_q.push_back(32'hD000_0000 | 32'(i));
    end
    for (int i = 0; i < 11; i++) exp_q.push_back(32'd0);
    idle(16);
    compare_stream("t4a");
    check_eq("t4a_err", 32'(err_cnt), 32'd1);

    // T4b: len=64 but s_last on word 20 -> 16 emitted, 4 discarded
    clear_obs();
    send(32'h0000_0040, 1'b0);
    exp_q.push_back(32'h0000_0040);
    for (int i = 1; i <= 19; i++) begin
      send(32'hE000_0000 | 32'(i), i == 19);
      if (i <= 15) exp_q.push_back(32'hE000_0000 | 32'(i));
    end
    idle(4);
    compare_stream("t4b");
    check_eq("t4b_err", 32'(err_cnt), 32'd2);
    check_eq("t4b_ready", 32'(s_ready), 32'd1);

    // T5: len=0 single word, then len=2048 over three words -> both dropped
    clear_obs();
    send(32'h0000_0000, 1'b1);
    send(32'h0000_0800, 1'b0);
    send(32'hF000_0001, 1'b0);
    send(32'hF000_0002, 1'b1);
    idle(4);
    check_eq("t5_words", 32'(got_q.size()), 32'd0);
    check_eq("t5_drop", 32'(drop_cnt), 32'd3);

    // T6: reset during BODY word 4
    clear_obs();
    send(32'h0003_0040, 1'b0);
    send(32'h1111_0001, 1'b0);
    send(32'h1111_0002, 1'b0);
    @(negedge clk);
    s_data  = 32'h1111_0003;
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_eq("t6_rst_we", 32'(write_en), 32'd0);
    check_eq("t6_rst_ready", 32'(s_ready), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("t6_hold_ready", 32'(s_ready), 32'd0);
    check_eq("t6_hold_err", 32'(err_cnt), 32'd0);
    check_eq("t6_hold_drop", 32'(drop_cnt), 32'd0);
    check_eq("t6_hold_dest", 32'(dest_port), 32'd0);
    rst_n = 1'b1;
    clear_obs();
    idle(3);
    check_eq("t6_no_we", 32'(got_q.size()), 32'd0);
    check_eq("t6_ready", 32'(s_ready), 32'd1);
    // Next packet: len=12 dest=1 -> 3 data + 5 zeros
    clear_obs();
    send(32'h0001_000C, 1'b0);
    send(32'h2222_0001, 1'b0);
    send(32'h2222_0002, 1'b1);
    exp_q.push_back(32'h0001_000C);
    exp_q.push_back(32'h2222_0001);
    exp_q.push_back(32'h2222_0002);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'd0);
    idle(10);
    compare_stream("t6_post");
    check_eq("t6_post_npe", 32'(npe_cnt), 32'd1);
    check_eq("t6_post_dest", 32'(dest_port), 32'd1);
    check_eq("t6_post_err", 32'(err_cnt), 32'd0);

    // T7: drive drop_cnt to all-ones with len=0 headers, then one more drop
    clear_obs();
    for (int i = 0; i < 65535; i++) send(32'h0000_0000, 1'b1);
    idle(2);
    check_eq("t7_at_max", 32'(drop_cnt), 32'h0000_FFFF);
    send(32'h0000_0000, 1'b1);
    idle(2);
    check_eq("t7_saturate", 32'(drop_cnt), 32'h0000_FFFF);
    check_eq("t7_words", 32'(got_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
